// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the pipeline FFT stages.
//   FFT_WIDTH       : default real/imag component width (two's complement).
//   fft_clog2       : ceil(log2(value)), constant-evaluable.
//   fft_clog2_min1  : as fft_clog2 but never below 1, for index/port widths.
//   fft_cnt_width   : width of a stage's sample counter, CNTW = clog2(2*DEPTH).
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_WIDTH = 16;

    // Loop form keeps the function usable in parameter expressions.
    function automatic int fft_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A zero-width vector is illegal, so widths derived from DEPTH=1 floor at 1.
    function automatic int fft_clog2_min1(input int value);
        int result;
        result = fft_clog2(value);
        return (result < 1) ? 1 : result;
    endfunction

    // Counter spans one full block of 2*DEPTH samples; its MSB is the phase.
    function automatic int fft_cnt_width(input int depth);
        return fft_clog2_min1(2 * depth);
    endfunction

endpackage

// File: rtl/r2sdf_stage_bfly.sv
// -----------------------------------------------------------------------------
// r2sdf_stage_bfly
// Combinational radix-2 butterfly on complex two's-complement operands.
//   sum  = (a + b) >>> SCALE
//   diff = (a - b) >>> SCALE
// Adds wrap modulo 2^WIDTH (no widening, no saturation); the shift is
// arithmetic so negative results keep their sign.
// Ports:
//   i_a_re/i_a_im   : operand a (delay-line head)
//   i_b_re/i_b_im   : operand b (incoming sample)
//   o_sum_re/o_sum_im   : scaled sum
//   o_diff_re/o_diff_im : scaled difference
// -----------------------------------------------------------------------------
module r2sdf_stage_bfly
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int SCALE = 0
)(
    input  logic [WIDTH-1:0] i_a_re,
    input  logic [WIDTH-1:0] i_a_im,
    input  logic [WIDTH-1:0] i_b_re,
    input  logic [WIDTH-1:0] i_b_im,
    output logic [WIDTH-1:0] o_sum_re,
    output logic [WIDTH-1:0] o_sum_im,
    output logic [WIDTH-1:0] o_diff_re,
    output logic [WIDTH-1:0] o_diff_im
);

    // Raw WIDTH-bit results; declared signed so >>> sign-extends.
    logic signed [WIDTH-1:0] w_sum_re;
    logic signed [WIDTH-1:0] w_sum_im;
    logic signed [WIDTH-1:0] w_diff_re;
    logic signed [WIDTH-1:0] w_diff_im;

    assign w_sum_re  = i_a_re + i_b_re;
    assign w_sum_im  = i_a_im + i_b_im;
    assign w_diff_re = i_a_re - i_b_re;
    assign w_diff_im = i_a_im - i_b_im;

    assign o_sum_re  = w_sum_re  >>> SCALE;
    assign o_sum_im  = w_sum_im  >>> SCALE;
    assign o_diff_re = w_diff_re >>> SCALE;
    assign o_diff_im = w_diff_im >>> SCALE;

endmodule

// File: rtl/r2sdf_stage.sv
// -----------------------------------------------------------------------------
// r2sdf_stage
// One radix-2 single-path delay-feedback stage of a pipeline FFT.
// The first half of each 2*DEPTH-sample block is parked in a feedback delay
// line; during the second half each stored sample is paired with the incoming
// one in the butterfly. Sums leave immediately, differences are written back
// into the delay line and leave during the next block's first half.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   i_valid   : input sample valid; low freezes all state
//   i_re/i_im : input sample
//   o_valid   : output sample valid (1 cycle after the accepted input)
//   o_re/o_im : output sample
//   o_idx     : position k within the half-block (twiddle index)
//   o_tw      : 1 = difference, downstream applies W^k; 0 = sum
// -----------------------------------------------------------------------------
module r2sdf_stage
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int DEPTH = 8,
    parameter int SCALE = 0,
    parameter int IDXW  = fft_clog2_min1(DEPTH)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_re,
    input  logic [WIDTH-1:0] i_im,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_re,
    output logic [WIDTH-1:0] o_im,
    output logic [IDXW-1:0]  o_idx,
    output logic             o_tw
);

    localparam int              CNTW     = fft_cnt_width(DEPTH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(2 * DEPTH - 1);

    // ---------------------------------------------------------------------
    // Block counter and phase
    // ---------------------------------------------------------------------
    logic [CNTW-1:0] r_cnt;
    logic            r_primed;
    logic            w_phase;
    logic [IDXW-1:0] w_k;

    assign w_phase = r_cnt[CNTW-1];

    // With DEPTH=1 the counter is only the phase bit, so k is always 0.
    generate
        if (CNTW > 1) begin : g_k_bits
            assign w_k = IDXW'(r_cnt[CNTW-2:0]);
        end else begin : g_k_zero
            assign w_k = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
        end else if (i_valid) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt    <= '0;
                // From here on the delay line holds real differences.
                r_primed <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Feedback delay line: entry 0 takes the pushed value, entry DEPTH-1 is
    // the head (written DEPTH accepted samples ago).
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] r_dly_re [DEPTH];
    logic [WIDTH-1:0] r_dly_im [DEPTH];
    logic [WIDTH-1:0] w_dly_next_re [DEPTH];
    logic [WIDTH-1:0] w_dly_next_im [DEPTH];
    logic [WIDTH-1:0] w_head_re;
    logic [WIDTH-1:0] w_head_im;
    logic [WIDTH-1:0] w_push_re;
    logic [WIDTH-1:0] w_push_im;

    assign w_head_re = r_dly_re[DEPTH-1];
    assign w_head_im = r_dly_im[DEPTH-1];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dly
            if (gi == 0) begin : g_tail
                assign w_dly_next_re[gi] = w_push_re;
                assign w_dly_next_im[gi] = w_push_im;
            end else begin : g_tap
                assign w_dly_next_re[gi] = r_dly_re[gi-1];
                assign w_dly_next_im[gi] = r_dly_im[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dly_re[i] <= '0;
                r_dly_im[i] <= '0;
            end
        end else if (i_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dly_re[i] <= w_dly_next_re[i];
                r_dly_im[i] <= w_dly_next_im[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Butterfly: a = head, b = incoming sample
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] w_sum_re;
    logic [WIDTH-1:0] w_sum_im;
    logic [WIDTH-1:0] w_diff_re;
    logic [WIDTH-1:0] w_diff_im;

    r2sdf_stage_bfly #(
        .WIDTH (WIDTH),
        .SCALE (SCALE)
    ) u_bfly (
        .i_a_re    (w_head_re),
        .i_a_im    (w_head_im),
        .i_b_re    (i_re),
        .i_b_im    (i_im),
        .o_sum_re  (w_sum_re),
        .o_sum_im  (w_sum_im),
        .o_diff_re (w_diff_re),
        .o_diff_im (w_diff_im)
    );

    // ---------------------------------------------------------------------
    // Phase muxes
    //   phase 0: store the input, emit the previous block's difference
    //            (only meaningful once a full block has been seen)
    //   phase 1: store the difference, emit the sum
    // ---------------------------------------------------------------------
    logic             w_cand_valid;
    logic [WIDTH-1:0] w_cand_re;
    logic [WIDTH-1:0] w_cand_im;
    logic             w_cand_tw;

    always_comb begin
        w_push_re    = i_re;
        w_push_im    = i_im;
        w_cand_valid = r_primed;
        w_cand_re    = w_head_re;
        w_cand_im    = w_head_im;
        w_cand_tw    = 1'b1;
        if (w_phase) begin
            w_push_re    = w_diff_re;
            w_push_im    = w_diff_im;
            w_cand_valid = 1'b1;
            w_cand_re    = w_sum_re;
            w_cand_im    = w_sum_im;
            w_cand_tw    = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Output register: one cycle latency; data holds across stalls while
    // the valid flag drops.
    // ---------------------------------------------------------------------
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_re;
    logic [WIDTH-1:0] r_out_im;
    logic [IDXW-1:0]  r_out_idx;
    logic             r_out_tw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_idx   <= '0;
            r_out_tw    <= 1'b0;
        end else if (i_valid) begin
            r_out_valid <= w_cand_valid;
            r_out_re    <= w_cand_re;
            r_out_im    <= w_cand_im;
            r_out_idx   <= w_k;
            r_out_tw    <= w_cand_tw;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_valid = r_out_valid;
    assign o_re    = r_out_re;
    assign o_im    = r_out_im;
    assign o_idx   = r_out_idx;
    assign o_tw    = r_out_tw;

endmodule
